// File: rtl/maze_game_if.sv
// Signal bundle between the maze game controller and the VGA timing / level renderer side.
// The controller is the master: it owns the player position and game status.
interface maze_game_if;
  logic [9:0] col;
  logic [8:0] row;
  logic [3:0] switches;
  logic       on_path;
  logic       at_finish;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [1:0] level;
  logic [1:0] lives;
  logic [2:0] state;
  logic       flash;
  logic       game_over;

  modport master (
    input  col, row, switches, on_path, at_finish,
    output player_x, player_y, level, lives, state, flash, game_over
  );

  modport slave (
    output col, row, switches, on_path, at_finish,
    input  player_x, player_y, level, lives, state, flash, game_over
  );
endinterface

// File: rtl/maze_game_controller.sv
// Per-frame sequencer for the maze game: player position, level, lives and game state.
// Everything advances on a one-cycle frame tick derived from the scan counters reaching (0,0).
module maze_game_controller #(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned START_X      = 113,
  parameter int unsigned START_Y      = 443,
  parameter int unsigned STEP         = 5,
  parameter int unsigned MOVE_FRAMES  = 2,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned WIN_FRAMES   = 120,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned MAX_X        = 615,
  parameter int unsigned MAX_Y        = 455
) (
  input  logic           pixel_clk,
  input  logic           resetSwitch,
  maze_game_if.master    bus
);

  typedef enum logic [2:0] {
    StReady    = 3'd0,
    StPlay     = 3'd1,
    StDying    = 3'd2,
    StLevelWon = 3'd3,
    StGameOver = 3'd4,
    StGameWon  = 3'd5
  } state_e;

  localparam int unsigned FrameMax = (WIN_FRAMES > DEATH_FRAMES) ? WIN_FRAMES : DEATH_FRAMES;
  // At least 4 bits so the flash tap (bit 3) always exists.
  localparam int unsigned FrameW   = ($clog2(FrameMax) < 4) ? 4 : $clog2(FrameMax);
  localparam int unsigned MoveW    = (MOVE_FRAMES < 2) ? 1 : $clog2(MOVE_FRAMES);

  localparam logic [9:0]        StartX   = 10'(START_X);
  localparam logic [9:0]        StartY   = 10'(START_Y);
  localparam logic [9:0]        StepV    = 10'(STEP);
  localparam logic [9:0]        MaxXV    = 10'(MAX_X);
  localparam logic [9:0]        MaxYV    = 10'(MAX_Y);
  localparam logic [9:0]        RightLim = 10'(MAX_X - STEP);
  localparam logic [9:0]        DownLim  = 10'(MAX_Y - STEP);
  localparam logic [1:0]        LivesV   = 2'(LIVES);
  localparam logic [1:0]        LastLvl  = 2'(NUM_LEVELS - 1);
  localparam logic [MoveW-1:0]  MoveLast = MoveW'(MOVE_FRAMES - 1);
  localparam logic [FrameW-1:0] DeadLast = FrameW'(DEATH_FRAMES - 1);
  localparam logic [FrameW-1:0] WinLast  = FrameW'(WIN_FRAMES - 1);

  state_e              state_q, state_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic [1:0]          level_q, level_d, lives_q, lives_d;
  logic [MoveW-1:0]    move_cnt_q, move_cnt_d;
  logic [FrameW-1:0]   frame_cnt_q, frame_cnt_d;
  logic                armed_q, armed_d;
  logic                flash_q, flash_d;
  logic                game_over_q, game_over_d;
  logic                origin_q;
  logic                at_origin, tick, sw_idle;

  assign at_origin = (bus.col == 10'd0) && (bus.row == 9'd0);
  assign tick      = at_origin && !origin_q;
  assign sw_idle   = (bus.switches == 4'd0);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    level_d     = level_q;
    lives_d     = lives_q;
    move_cnt_d  = move_cnt_q;
    frame_cnt_d = frame_cnt_q;
    armed_d     = armed_q;

    if (tick) begin
      if (sw_idle) armed_d = 1'b1;
      case (state_q)
        StReady: begin
          x_d        = StartX;
          y_d        = StartY;
          move_cnt_d = '0;
          if (armed_q && !sw_idle) begin
            state_d = StPlay;
            armed_d = 1'b0;
          end
        end
        StPlay: begin
          if (bus.at_finish) begin
            state_d     = StLevelWon;
            frame_cnt_d = '0;
          end else if (!bus.on_path) begin
            frame_cnt_d = '0;
            lives_d     = lives_q - 2'd1;
            state_d     = (lives_q == 2'd1) ? StGameOver : StDying;
          end else if (sw_idle) begin
            move_cnt_d = '0;
          end else if (move_cnt_q == MoveLast) begin
            move_cnt_d = '0;
            // Direction priority: left > up > down > right, saturating at the screen edges.
            if (bus.switches[3])      x_d = (x_q < StepV)     ? 10'd0 : x_q - StepV;
            else if (bus.switches[2]) y_d = (y_q < StepV)     ? 10'd0 : y_q - StepV;
            else if (bus.switches[1]) y_d = (y_q >= DownLim)  ? MaxYV : y_q + StepV;
            else                      x_d = (x_q >= RightLim) ? MaxXV : x_q + StepV;
          end else begin
            move_cnt_d = move_cnt_q + 1'b1;
          end
        end
        StDying: begin
          if (frame_cnt_q == DeadLast) begin
            frame_cnt_d = '0;
            x_d         = StartX;
            y_d         = StartY;
            state_d     = StReady;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        StLevelWon: begin
          if (frame_cnt_q == WinLast) begin
            frame_cnt_d = '0;
            x_d         = StartX;
            y_d         = StartY;
            if (level_q == LastLvl) begin
              state_d = StGameWon;
            end else begin
              level_d = level_q + 2'd1;
              state_d = StReady;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        StGameOver, StGameWon: begin
          if (armed_q && !sw_idle) begin
            level_d = 2'd0;
            lives_d = LivesV;
            x_d     = StartX;
            y_d     = StartY;
            armed_d = 1'b0;
            state_d = StReady;
          end
        end
        default: state_d = StReady;
      endcase
    end

    flash_d     = (state_d == StDying) && frame_cnt_d[3];
    game_over_d = (state_d == StGameOver) || (state_d == StGameWon);
  end

  always_ff @(posedge pixel_clk) begin
    if (resetSwitch) begin
      state_q     <= StReady;
      x_q         <= StartX;
      y_q         <= StartY;
      level_q     <= 2'd0;
      lives_q     <= LivesV;
      move_cnt_q  <= '0;
      frame_cnt_q <= '0;
      armed_q     <= 1'b0;
      flash_q     <= 1'b0;
      game_over_q <= 1'b0;
      origin_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      move_cnt_q  <= move_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      armed_q     <= armed_d;
      flash_q     <= flash_d;
      game_over_q <= game_over_d;
      origin_q    <= at_origin;
    end
  end

  assign bus.player_x  = x_q;
  assign bus.player_y  = y_q;
  assign bus.level     = level_q;
  assign bus.lives     = lives_q;
  assign bus.state     = state_q;
  assign bus.flash     = flash_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_maze_game_controller.sv
// Directed bench for maze_game_controller; each "frame" is a one-cycle (0,0) scan position
// followed by one off-origin cycle.
module tb_maze_game_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  maze_game_if bus ();

  maze_game_controller dut (
    .pixel_clk   (clk),
    .resetSwitch (rst),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    bus.col = 10'd0;
    bus.row = 9'd0;
    @(negedge clk);
    bus.col = 10'd1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(bus.player_x), 32'(x));
    check({tag, "_y"}, 32'(bus.player_y), 32'(y));
  endtask

  // From READY: arm with idle switches, press to enter PLAY, then hit the finish.
  task automatic win_level(input int lvl_after, input int st_after);
    bus.switches = 4'b0000;
    frame();
    bus.switches = 4'b0001;
    frame();
    check("win_play", 32'(bus.state), 32'd1);
    bus.switches  = 4'b0000;
    bus.at_finish = 1'b1;
    bus.on_path   = 1'b0;
    frame();
    check("win_state", 32'(bus.state), 32'd3);
    check("win_lives", 32'(bus.lives), 32'd3);
    bus.at_finish = 1'b0;
    bus.on_path   = 1'b1;
    frames(119);
    check("win_hold", 32'(bus.state), 32'd3);
    frame();
    check("win_next", 32'(bus.state), 32'(st_after));
    check("win_level", 32'(bus.level), 32'(lvl_after));
    check_pos("win_pos", 113, 443);
  endtask

  initial begin
    bus.col       = 10'd1;
    bus.row       = 9'd0;
    bus.switches  = 4'b0000;
    bus.on_path   = 1'b1;
    bus.at_finish = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check_pos("rst_pos", 113, 443);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_lives", 32'(bus.lives), 32'd3);
    check("rst_flash", 32'(bus.flash), 32'd0);
    check("rst_gover", 32'(bus.game_over), 32'd0);
    rst = 1'b0;

    frames(5);
    check("idle_state", 32'(bus.state), 32'd0);
    check_pos("idle_pos", 113, 443);

    // Up held: PLAY on first tick, first step after two more ticks.
    bus.switches = 4'b0100;
    frame();
    check("up_play", 32'(bus.state), 32'd1);
    frame();
    check("up_t2", 32'(bus.player_y), 32'd443);
    frame();
    check("up_t3", 32'(bus.player_y), 32'd438);
    frames(2);
    check("up_t5", 32'(bus.player_y), 32'd433);

    // All switches: only left moves; saturates at 0.
    bus.switches = 4'b1111;
    frames(44);
    check_pos("left_3", 3, 433);
    frames(2);
    check("left_0", 32'(bus.player_x), 32'd0);
    frames(2);
    check("left_hold", 32'(bus.player_x), 32'd0);

    bus.switches = 4'b0010;
    frames(10);
    check_pos("down_max", 0, 455);
    frames(2);
    check("down_hold", 32'(bus.player_y), 32'd455);

    // Off path: DYING with blinking sprite, then respawn.
    bus.switches = 4'b0000;
    bus.on_path  = 1'b0;
    frame();
    check("die_state", 32'(bus.state), 32'd2);
    check("die_lives", 32'(bus.lives), 32'd2);
    bus.on_path = 1'b1;
    frames(7);
    check("flash_c7", 32'(bus.flash), 32'd0);
    frame();
    check("flash_c8", 32'(bus.flash), 32'd1);
    frames(7);
    check("flash_c15", 32'(bus.flash), 32'd1);
    frame();
    check("flash_c16", 32'(bus.flash), 32'd0);
    frames(43);
    check("die_hold", 32'(bus.state), 32'd2);
    frame();
    check("die_ready", 32'(bus.state), 32'd0);
    check_pos("die_pos", 113, 443);
    check("die_flash", 32'(bus.flash), 32'd0);

    // Second death.
    bus.switches = 4'b0001;
    frame();
    bus.switches = 4'b0000;
    bus.on_path  = 1'b0;
    frame();
    check("die2_lives", 32'(bus.lives), 32'd1);
    bus.on_path = 1'b1;
    frames(60);
    check("die2_ready", 32'(bus.state), 32'd0);

    // Last life lost.
    bus.switches = 4'b0001;
    frame();
    bus.switches = 4'b0000;
    bus.on_path  = 1'b0;
    frame();
    check("go_state", 32'(bus.state), 32'd4);
    check("go_lives", 32'(bus.lives), 32'd0);
    check("go_flag", 32'(bus.game_over), 32'd1);
    bus.on_path = 1'b1;
    frame();
    bus.switches = 4'b0001;
    frame();
    check("go_restart", 32'(bus.state), 32'd0);
    check("go_lives3", 32'(bus.lives), 32'd3);
    check("go_level0", 32'(bus.level), 32'd0);
    check("go_flag0", 32'(bus.game_over), 32'd0);

    win_level(1, 0);
    win_level(2, 0);
    win_level(2, 5);
    check("gw_flag", 32'(bus.game_over), 32'd1);

    // Restart, die, reset mid-DYING.
    bus.switches = 4'b0000;
    frame();
    bus.switches = 4'b0001;
    frame();
    check("gw_restart", 32'(bus.state), 32'd0);
    bus.switches = 4'b0000;
    frame();
    bus.switches = 4'b0001;
    frame();
    bus.switches = 4'b0000;
    bus.on_path  = 1'b0;
    frame();
    bus.on_path = 1'b1;
    frames(30);
    check("d30_state", 32'(bus.state), 32'd2);
    check("d30_flash", 32'(bus.flash), 32'd1);
    check("d30_lives", 32'(bus.lives), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_state", 32'(bus.state), 32'd0);
    check("mrst_lives", 32'(bus.lives), 32'd3);
    check_pos("mrst_pos", 113, 443);
    check("mrst_flash", 32'(bus.flash), 32'd0);
    rst = 1'b0;

    // Holding (0,0) for 10 cycles must produce exactly one tick.
    frame();
    bus.switches = 4'b0100;
    frame();
    check("hold_play", 32'(bus.state), 32'd1);
    @(negedge clk);
    bus.col = 10'd0;
    bus.row = 9'd0;
    repeat (10) @(negedge clk);
    bus.col = 10'd1;
    check("hold_one", 32'(bus.player_y), 32'd443);
    frame();
    check("hold_step", 32'(bus.player_y), 32'd438);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
